collision_tracker: RTL and testbench

//  Per-frame sprite overlap detector. Feeds the 17-bit collision vector into the sprite priority chooser.

---
 rtl/collision_tracker.sv | 111 +++++++++++
 tb/tb_collision_tracker.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/collision_tracker.sv
// Per-frame sprite overlap detector: counts overlapping drawn pixels per sprite and publishes flags at frame_start.
// Optional COLLISION_STICKY_EN: flags accumulate across frames until the consumer acknowledges.
module collision_tracker #(
  parameter int unsigned NUM_SPRITES = 17,
  parameter int unsigned MIN_OVERLAP = 2
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     frame_start,
  input  logic                     pixel_en,
  input  logic [4*NUM_SPRITES-1:0] sprite_codes,
  input  logic                     collision_ack,
  output logic [NUM_SPRITES-1:0]   collision,
  output logic                     collision_valid
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic {ARM, SCAN} state_t;

  state_t                 state;
  logic [NUM_SPRITES-1:0] hit;
  logic                   en_d;
  logic [CNT_W-1:0]       cnt [NUM_SPRITES];

  logic [NUM_SPRITES-1:0] hit_c;
  logic [NUM_SPRITES-1:0] flags_c;
  logic [NUM_SPRITES-1:0] latch_c;
  logic                   overlap_c;

  // A sprite is drawn on this pixel when its colour code is non-transparent.
  always_comb begin
    hit_c = '0;
    for (int i = 0; i < int'(NUM_SPRITES); i++) begin
      hit_c[i] = (sprite_codes[4*i +: 4] != 4'h0);
    end
  end

  always_comb begin
    overlap_c = en_d && ($countones(hit) >= 2);
    flags_c   = '0;
    for (int i = 0; i < int'(NUM_SPRITES); i++) begin
      flags_c[i] = (cnt[i] == CNT_W'(MIN_OVERLAP));
    end
  end

  // An ack arriving with the latch means the old data was consumed, so it does not accumulate.
`ifdef COLLISION_STICKY_EN
  always_comb begin
    latch_c = flags_c;
    if (collision_valid && !collision_ack) begin
      latch_c = collision | flags_c;
    end
  end
`else
  always_comb begin
    latch_c = flags_c;
  end
`endif

  // Stage 1: registered pixel snapshot.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hit  <= '0;
      en_d <= 1'b0;
    end else begin
      hit  <= hit_c;
      en_d <= pixel_en;
    end
  end

  // Frame FSM, per-sprite saturating counters and the published result.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state           <= ARM;
      collision       <= '0;
      collision_valid <= 1'b0;
      for (int i = 0; i < int'(NUM_SPRITES); i++) begin
        cnt[i] <= '0;
      end
    end else begin
      if (collision_ack) begin
        collision_valid <= 1'b0;
      end
      case (state)
        ARM: begin
          if (frame_start) begin
            state <= SCAN;
          end
        end
        SCAN: begin
          if (frame_start) begin
            collision       <= latch_c;
            collision_valid <= 1'b1;
            for (int i = 0; i < int'(NUM_SPRITES); i++) begin
              cnt[i] <= '0;
            end
          end else begin
            for (int i = 0; i < int'(NUM_SPRITES); i++) begin
              if (overlap_c && hit[i] && (cnt[i] < CNT_W'(MIN_OVERLAP))) begin
                cnt[i] <= cnt[i] + CNT_W'(1);
              end
            end
          end
        end
        default: state <= ARM;
      endcase
    end
  end

endmodule

// File: tb/tb_collision_tracker.sv
// Bench for collision_tracker: directed scenarios plus random traffic against a frame-level reference model.
module tb_collision_tracker;

  localparam int unsigned N   = 17;
  localparam int unsigned MIN = 2;

  logic           Clk = 1'b0;
  logic           Reset;
  logic           frame_start;
  logic           pixel_en;
  logic [4*N-1:0] sprite_codes;
  logic           collision_ack;
  logic [N-1:0]   collision;
  logic           collision_valid;

  int total = 0;
  int bad   = 0;

  // Reference model state: raw overlap counts per sprite in the current frame.
  int         cnt_m [N];
  logic [N-1:0] pend_m = '0;
  bit         scan_m = 1'b0;
  logic [N-1:0] col_m = '0;
  bit         val_m = 1'b0;

  collision_tracker #(.NUM_SPRITES(N), .MIN_OVERLAP(MIN)) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .pixel_en(pixel_en),
    .sprite_codes(sprite_codes), .collision_ack(collision_ack),
    .collision(collision), .collision_valid(collision_valid)
  );

  always #5 Clk = ~Clk;

  function automatic logic [4*N-1:0] mk(input logic [N-1:0] mask);
    logic [4*N-1:0] c;
    c = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (mask[i]) c[4*i +: 4] = 4'($urandom_range(1, 15));
    end
    return c;
  endfunction

  // Sprites credited by one pixel: all drawn sprites, if at least two are drawn on an enabled pixel.
  function automatic logic [N-1:0] involved(input logic [4*N-1:0] c, input bit en);
    logic [N-1:0] m;
    int n;
    m = '0;
    n = 0;
    for (int i = 0; i < int'(N); i++) begin
      if (c[4*i +: 4] != 4'h0) begin
        m[i] = 1'b1;
        n++;
      end
    end
    return (en && n >= 2) ? m : '0;
  endfunction

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit fs, input bit en,
                      input logic [4*N-1:0] codes, input bit ack);
    logic [N-1:0] newf;
    bit old_val;
    Reset = rst; frame_start = fs; pixel_en = en; sprite_codes = codes; collision_ack = ack;
    @(posedge Clk);
    if (rst) begin
      for (int i = 0; i < int'(N); i++) cnt_m[i] = 0;
      scan_m = 1'b0; col_m = '0; val_m = 1'b0; pend_m = '0;
    end else begin
      old_val = val_m;
      if (ack) val_m = 1'b0;
      if (fs) begin
        // The pixel one cycle before frame_start falls into neither frame.
        if (scan_m) begin
          for (int i = 0; i < int'(N); i++) newf[i] = (cnt_m[i] >= int'(MIN));
`ifdef COLLISION_STICKY_EN
          col_m = (old_val && !ack) ? (col_m | newf) : newf;
`else
          col_m = newf;
`endif
          val_m = 1'b1;
        end
        for (int i = 0; i < int'(N); i++) cnt_m[i] = 0;
        scan_m = 1'b1;
      end else if (scan_m) begin
        for (int i = 0; i < int'(N); i++) if (pend_m[i]) cnt_m[i]++;
      end
      pend_m = involved(codes, en);
    end
    #1;
    chk("collision", collision, col_m);
    chk("valid", N'(collision_valid), N'(val_m));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic fs_step(input bit ack);
    step(1'b0, 1'b1, 1'b0, '0, ack);
  endtask

  initial begin
    for (int i = 0; i < int'(N); i++) cnt_m[i] = 0;

    // T1: reset, overlaps in the discarded ARM frame, then an empty frame
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("t1_reset_col", collision, 17'h00000);
    chk("t1_reset_val", N'(collision_valid), 17'h00000);
    repeat (3) step(1'b0, 1'b0, 1'b1, mk(17'h08001), 1'b0);
    idle();
    fs_step(1'b0);
    chk("t1_arm_col", collision, 17'h00000);
    chk("t1_arm_val", N'(collision_valid), 17'h00000);
    repeat (2) step(1'b0, 1'b0, 1'b1, mk(17'h00002), 1'b0);
    fs_step(1'b0);
    chk("t1_empty_col", collision, 17'h00000);
    chk("t1_empty_val", N'(collision_valid), 17'h00001);

    // T2: three overlapping pixels
    repeat (3) step(1'b0, 1'b0, 1'b1, mk(17'h08001), 1'b0);
    idle();
    fs_step(1'b0);
    chk("t2_col", collision, 17'h08001);
    chk("t2_val", N'(collision_valid), 17'h00001);

    // T3: a single overlapping pixel is below threshold
    step(1'b0, 1'b0, 1'b1, mk(17'h08001), 1'b0);
    idle();
    fs_step(1'b0);
    chk("t3_col", collision, 17'h00000);

    // T4: three-way overlap, disabled then enabled
    repeat (5) step(1'b0, 1'b0, 1'b0, mk(17'h10006), 1'b0);
    idle();
    fs_step(1'b0);
    chk("t4_off_col", collision, 17'h00000);
    repeat (5) step(1'b0, 1'b0, 1'b1, mk(17'h10006), 1'b0);
    idle();
    fs_step(1'b0);
    chk("t4_on_col", collision, 17'h10006);

    // Last pixel right before frame_start is discarded
    step(1'b0, 1'b0, 1'b1, mk(17'h00003), 1'b0);
    step(1'b0, 1'b0, 1'b1, mk(17'h00003), 1'b0);
    fs_step(1'b0);
    chk("edge_discard_col", collision, 17'h00000);

    // T5: ack coinciding with latch, then ack alone
    repeat (2) step(1'b0, 1'b0, 1'b1, mk(17'h00003), 1'b0);
    idle();
    fs_step(1'b1);
    chk("t5_same_val", N'(collision_valid), 17'h00001);
    chk("t5_same_col", collision, 17'h00003);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    chk("t5_ack_val", N'(collision_valid), 17'h00000);
    chk("t5_ack_col", collision, 17'h00003);

    // T6: two frames without ack in between
    step(1'b0, 1'b0, 1'b1, mk(17'h00021), 1'b0);
    step(1'b0, 1'b0, 1'b1, mk(17'h00041), 1'b0);
    idle();
    fs_step(1'b0);
    chk("t6_a_col", collision, 17'h00001);
    step(1'b0, 1'b0, 1'b1, mk(17'h00021), 1'b0);
    step(1'b0, 1'b0, 1'b1, mk(17'h00060), 1'b0);
    idle();
    fs_step(1'b0);
`ifdef COLLISION_STICKY_EN
    chk("t6_b_col", collision, 17'h00021);
`else
    chk("t6_b_col", collision, 17'h00020);
`endif

    // Random traffic, including mid-frame resets and frame_start during active pixels
    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] m;
      for (int i = 0; i < int'(N); i++) m[i] = ($urandom_range(0, 7) == 0);
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 3) != 0), mk(m), ($urandom_range(0, 9) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
